dac_row_sequencer: RTL and testbench
====================================

# dac_row_sequencer

Sequences a vector of wordline input codes through the single shared 10-bit wordline DAC, one row at a time. It issues each code on the DAC's valid/code inputs, waits for the DAC's conversion-complete pulse, and captures the returned millivolt value into a per-row voltage register. The block sits between the layer controller, which supplies the input vector and `start`, and the DAC/ReRAM row drivers. A per-row watchdog aborts the vector if the DAC never answers.

## Interface
- `NUM_ROWS`, 8: rows per vector; ≥1.
- `DAC_BITS`, 10: code width.
- `TIMEOUT_CYC`, 15: maximum `WAIT` cycles per row before abort; ≥2.
- `IDX_W`, `$clog2(NUM_ROWS)`, minimum 1: row index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a vector; sampled only in `IDLE`.
- `row_codes` in `NUM_ROWS*DAC_BITS`: flat codes; row r at `[r*DAC_BITS +: DAC_BITS]`.
- `busy` out 1: high from the cycle after `start` is accepted until completion or abort.
- `done` out 1: one-cycle pulse when all rows are captured.
- `error` out 1: one-cycle pulse on watchdog abort.
- `dac_code` out `DAC_BITS`: code presented to the DAC.
- `dac_valid` out 1: one-cycle request pulse to the DAC.
- `dac_mv` in 16: DAC output value, in mV.
- `dac_ready` in 1: DAC conversion-complete pulse.
- `row_idx` out `IDX_W`: row currently being served.
- `row_mv` out `NUM_ROWS*16`: captured voltages; row r at `[r*16 +: 16]`.

## Operation
- FSM states: `IDLE`, `ISSUE`, `WAIT`. All outputs are registered.
- **`IDLE`**
  - On `start`: snapshot `row_codes` into an internal shadow register, set `row_idx`=0, set `busy`=1, go to `ISSUE`.
  - `row_codes` changes after acceptance have no effect on the vector in flight.
- **`ISSUE`**
  - `dac_code`<=shadow[`row_idx`], `dac_valid`<=1 for exactly one cycle.
  - Clear the watchdog counter, go to `WAIT`.
- **`WAIT`**
  - The watchdog counter increments each cycle.
  - On `dac_ready`: `row_mv[row_idx]`<=`dac_mv`.
    - If `row_idx`==`NUM_ROWS`-1: `done`<=1, `busy`<=0, go to `IDLE`.
    - Otherwise: `row_idx`++, go to `ISSUE`.
  - If `TIMEOUT_CYC` consecutive `WAIT` cycles pass without `dac_ready`: `error`<=1, `busy`<=0, go to `IDLE`.
    - Rows already captured keep their values; the failing row and later rows keep their prior values.
- `dac_ready` arriving on the same edge the timeout expires counts as success; no error is raised.
- `dac_ready` in `IDLE` or `ISSUE` is ignored.
- `start` while `busy`=1 is ignored and not queued.
- `start` held high continuously restarts a new vector on the first `IDLE` cycle after `done`.
- `row_mv` changes only on a capture. It is never cleared between vectors, only by reset.
- `row_idx` holds its last value in `IDLE`.

## Timing
- Reset value of all outputs and internal state is 0; `row_mv` resets to all zeros.
- Reset asserted mid-vector aborts immediately without a `done` or `error` pulse. `dac_valid` drops asynchronously.
- Let L = cycles from the `dac_valid` rising edge to the `dac_ready` rising edge. L=4 for the shared wordline DAC.
- Per-row period is L+2 cycles.
- `done` rises N·(L+2) cycles after the edge that samples `start`: 48 cycles for N=8, L=4.
- The first `dac_valid` rises 1 cycle after `start` is sampled.
- Watchdog: `error` rises on the `TIMEOUT_CYC`-th `WAIT` edge without ready, i.e. `TIMEOUT_CYC`+1 cycles after `dac_valid` rose.

## Configuration
- `DAC_SEQ_ZERO_SKIP_EN`
  - **Defined:** in `ISSUE`, a row whose code is 0 is not sent to the DAC. `dac_valid` stays low and `row_mv[row_idx]`<=0 that cycle. The FSM then advances `row_idx` and stays in `ISSUE`; on the last row it pulses `done` and returns to `IDLE`. A skipped row costs 1 cycle and never arms the watchdog.
  - **Undefined:** every row, including code 0, takes the full DAC handshake.

## Test plan
- **Reset:** assert `rst_n`=0 mid-`WAIT` -> `busy`, `done`, `error` and `dac_valid` all 0, `row_mv` all 0. No DAC request until the next `start`.
- **Full vector:** N=8, codes 0,146,…,1023, DAC model with L=4 returning `code*300/1023` -> 8 `dac_valid` pulses 6 cycles apart, `row_mv[7]`=300, `row_mv[0]`=0. `done` is a single pulse 48 cycles after `start`.
- **Timeout:** model drops `dac_ready` for row 3 -> `error` pulses 16 cycles after row 3's `dac_valid`. `row_mv[0..2]` are valid, `row_mv[3..7]` are unchanged, `done` never pulses.
- **Start while busy:** pulse `start` again during row 2 and change `row_codes` -> no restart, the original codes complete, exactly one `done`.
- **Ready/timeout collision:** `dac_ready` asserted exactly on the timeout edge -> value captured, no `error`, sequencing continues.
- **Zero skip, macro defined:** all-zero vector -> no `dac_valid` pulses, `done` 8 cycles after `start`. Mixed vector -> only nonzero rows handshake.

Source files
------------

// File: rtl/dac_row_sequencer_if.sv
// DAC request/response channel between the row sequencer and the wordline DAC.
// The sequencer drives code/valid; the DAC answers with a ready pulse and millivolts.
interface dac_row_sequencer_if #(
    parameter int DAC_BITS = 10
);
    logic [DAC_BITS-1:0] dac_code;
    logic                dac_valid;
    logic [15:0]         dac_mv;
    logic                dac_ready;

    modport master (
        output dac_code,
        output dac_valid,
        input  dac_mv,
        input  dac_ready
    );

    modport slave (
        input  dac_code,
        input  dac_valid,
        output dac_mv,
        output dac_ready
    );
endinterface

// File: rtl/dac_row_sequencer.sv
// Streams a code vector through the shared wordline DAC one row at a time.
// Option DAC_SEQ_ZERO_SKIP_EN: code-0 rows bypass the DAC and capture 0 mV.
module dac_row_sequencer #(
    parameter int NUM_ROWS    = 8,
    parameter int DAC_BITS    = 10,
    parameter int TIMEOUT_CYC = 15,
    parameter int IDX_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NUM_ROWS*DAC_BITS-1:0] row_codes,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [IDX_W-1:0]             row_idx,
    output logic [NUM_ROWS*16-1:0]       row_mv,
    dac_row_sequencer_if.master          dac
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                       r_state,  w_state;
    logic [NUM_ROWS*DAC_BITS-1:0] r_shadow, w_shadow;
    logic [IDX_W-1:0]             r_idx,    w_idx;
    logic [CNT_W-1:0]             r_cnt,    w_cnt;
    logic                         r_busy,   w_busy;
    logic                         r_done,   w_done;
    logic                         r_error,  w_error;
    logic [DAC_BITS-1:0]          r_code,   w_code;
    logic                         r_valid,  w_valid;
    logic [NUM_ROWS*16-1:0]       r_mv,     w_mv;

    logic [DAC_BITS-1:0]          w_cur;
    logic                         w_last;

    assign w_cur  = r_shadow[int'(r_idx)*DAC_BITS +: DAC_BITS];
    assign w_last = (r_idx == IDX_W'(NUM_ROWS - 1));

    always_comb begin
        w_state  = r_state;
        w_shadow = r_shadow;
        w_idx    = r_idx;
        w_cnt    = r_cnt;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_error  = 1'b0;
        w_code   = r_code;
        w_valid  = 1'b0;
        w_mv     = r_mv;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_shadow = row_codes;
                    w_idx    = '0;
                    w_busy   = 1'b1;
                    w_state  = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef DAC_SEQ_ZERO_SKIP_EN
                if (w_cur == '0) begin
                    w_mv[int'(r_idx)*16 +: 16] = '0;
                    if (w_last) begin
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_state = S_IDLE;
                    end else begin
                        w_idx = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_code  = w_cur;
                    w_valid = 1'b1;
                    w_cnt   = '0;
                    w_state = S_WAIT;
                end
`else
                w_code  = w_cur;
                w_valid = 1'b1;
                w_cnt   = '0;
                w_state = S_WAIT;
`endif
            end
            S_WAIT: begin
                // A ready on the expiry edge still wins over the watchdog
                if (dac.dac_ready) begin
                    w_mv[int'(r_idx)*16 +: 16] = dac.dac_mv;
                    if (w_last) begin
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_state = S_IDLE;
                    end else begin
                        w_idx   = r_idx + IDX_W'(1);
                        w_state = S_ISSUE;
                    end
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC)) begin
                    w_error = 1'b1;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_code   <= '0;
            r_valid  <= 1'b0;
            r_mv     <= '0;
        end else begin
            r_state  <= w_state;
            r_shadow <= w_shadow;
            r_idx    <= w_idx;
            r_cnt    <= w_cnt;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_error  <= w_error;
            r_code   <= w_code;
            r_valid  <= w_valid;
            r_mv     <= w_mv;
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign row_idx       = r_idx;
    assign row_mv        = r_mv;
    assign dac.dac_code  = r_code;
    assign dac.dac_valid = r_valid;
endmodule

// File: tb/tb_dac_row_sequencer.sv
// Bench for dac_row_sequencer: DAC model with per-request latency plus an
// event-schedule model of the expected outputs, checked every cycle.
module tb_dac_row_sequencer;
    localparam int N     = 8;
    localparam int DB    = 10;
    localparam int TO    = 15;
    localparam int IW    = 3;
    localparam int NEVER = 0;
`ifdef DAC_SEQ_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    localparam int K_BUSY  = 0;
    localparam int K_IDX   = 1;
    localparam int K_VALID = 2;
    localparam int K_MV    = 3;
    localparam int K_DONE  = 4;
    localparam int K_ERR   = 5;

    typedef struct {
        int e;
        int k;
        int r;
        int v;
    } act_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [N*DB-1:0] row_codes = '0;
    logic            busy, done, error;
    logic [IW-1:0]   row_idx;
    logic [N*16-1:0] row_mv;

    dac_row_sequencer_if #(.DAC_BITS(DB)) dif ();

    dac_row_sequencer #(
        .NUM_ROWS(N), .DAC_BITS(DB), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .row_codes(row_codes),
        .busy(busy), .done(done), .error(error), .row_idx(row_idx),
        .row_mv(row_mv), .dac(dif)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    act_t aq[$];
    int   lat_q[$];
    int   dac_k = 0;
    logic [DB-1:0] dac_pend = '0;

    int m_busy = 0, m_idx = 0, m_code = 0;
    int m_valid = 0, m_done = 0, m_err = 0;
    int m_mv[N] = '{default: 0};

    int done_e[$];
    int err_e[$];
    int n_valid = 0;

    function automatic void chk(string nm, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endfunction

    function automatic int mvf(int c);
        return c * 300 / 1023;
    endfunction

    function automatic void push(int e, int k, int r, int v);
        aq.push_back(act_t'{e, k, r, v});
    endfunction

    function automatic logic [N*DB-1:0] pack(int c[N]);
        logic [N*DB-1:0] v;
        v = '0;
        for (int r = 0; r < N; r++) v[r*DB +: DB] = DB'(c[r]);
        return v;
    endfunction

    // Schedule of output events for a vector whose start is sampled on edge s
    function automatic int plan(int s, int c[N], int l[N]);
        int t;
        int ce;
        t = s + 1;
        push(s, K_BUSY, 0, 1);
        for (int r = 0; r < N; r++) begin
            push(t - 1, K_IDX, 0, r);
            if (SKIP && c[r] == 0) begin
                push(t, K_MV, r, 0);
                if (r == N - 1) begin
                    push(t, K_DONE, 0, 1);
                    push(t, K_BUSY, 0, 0);
                    return t;
                end
                t++;
                continue;
            end
            push(t, K_VALID, 0, c[r]);
            lat_q.push_back(l[r]);
            if (l[r] != NEVER && l[r] <= TO) begin
                ce = t + l[r] + 1;
                push(ce, K_MV, r, mvf(c[r]));
                if (r == N - 1) begin
                    push(ce, K_DONE, 0, 1);
                    push(ce, K_BUSY, 0, 0);
                    return ce;
                end
                t = ce + 1;
            end else begin
                push(t + TO + 1, K_ERR, 0, 1);
                push(t + TO + 1, K_BUSY, 0, 0);
                return t + TO + 1;
            end
        end
        return t;
    endfunction

    function automatic void flush();
        aq.delete();
        lat_q.delete();
        dac_k = 0;
        m_busy = 0; m_idx = 0; m_code = 0;
        for (int r = 0; r < N; r++) m_mv[r] = 0;
    endfunction

    function automatic void clear_obs();
        done_e.delete();
        err_e.delete();
        n_valid = 0;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Wordline DAC: ready pulses L cycles after the valid rising edge
    initial begin
        dif.dac_ready = 1'b0;
        dif.dac_mv = '0;
        forever begin
            @(negedge clk);
            dif.dac_ready = 1'b0;
            if (dac_k > 0) begin
                dac_k--;
                if (dac_k == 0) begin
                    dif.dac_ready = 1'b1;
                    dif.dac_mv = 16'(mvf(int'(dac_pend)));
                end
            end
            if (dif.dac_valid) begin
                dac_pend = dif.dac_code;
                dac_k = (lat_q.size() > 0) ? lat_q.pop_front() : 4;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        m_valid = 0; m_done = 0; m_err = 0;
        foreach (aq[i]) begin
            if (aq[i].e == cyc) begin
                case (aq[i].k)
                    K_BUSY:  m_busy = aq[i].v;
                    K_IDX:   m_idx = aq[i].v;
                    K_VALID: begin m_valid = 1; m_code = aq[i].v; end
                    K_MV:    m_mv[aq[i].r] = aq[i].v;
                    K_DONE:  m_done = 1;
                    K_ERR:   m_err = 1;
                    default: ;
                endcase
            end
        end
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("error", error, m_err);
        chk("dac_valid", dif.dac_valid, m_valid);
        chk("dac_code", dif.dac_code, m_code);
        chk("row_idx", row_idx, m_idx);
        for (int r = 0; r < N; r++) chk("row_mv", row_mv[r*16 +: 16], m_mv[r]);
        if (done) done_e.push_back(cyc);
        if (error) err_e.push_back(cyc);
        if (dif.dac_valid) n_valid++;
    end

    task automatic go(input int c[N], input int l[N], output int s, output int e);
        @(negedge clk);
        row_codes = pack(c);
        start = 1'b1;
        s = cyc + 1;
        e = plan(s, c, l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_to(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    initial begin
        int c[N];
        int l[N];
        int s, e, s2, e2;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", dif.dac_valid, 0);
        chk("rst_row_mv", (row_mv == '0), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        c = '{0, 146, 292, 438, 584, 730, 876, 1023};
        l = '{default: 4};
        clear_obs();
        go(c, l, s, e);
        wait_to(e + 3);
        chk("full_done_cnt", done_e.size(), 1);
        if (done_e.size() > 0) chk("full_done_lat", done_e[0] - s, SKIP ? 43 : 48);
        chk("full_valid_cnt", n_valid, SKIP ? 7 : 8);
        chk("full_mv7", row_mv[7*16 +: 16], 300);
        chk("full_mv0", row_mv[0 +: 16], 0);
        chk("full_mv1", row_mv[16 +: 16], 42);

        c = '{default: 1023};
        l = '{4, 4, 4, NEVER, 4, 4, 4, 4};
        clear_obs();
        go(c, l, s, e);
        wait_to(e + 5);
        chk("to_err_cnt", err_e.size(), 1);
        if (err_e.size() > 0) chk("to_err_lat", err_e[0] - s, 35);
        chk("to_done_cnt", done_e.size(), 0);
        chk("to_valid_cnt", n_valid, 4);
        chk("to_mv2", row_mv[2*16 +: 16], 300);
        chk("to_mv3_kept", row_mv[3*16 +: 16], 128);

        for (int r = 0; r < N; r++) c[r] = 50 + 100 * r;
        l = '{default: 4};
        clear_obs();
        go(c, l, s, e);
        wait_to(s + 12);
        start = 1'b1;
        row_codes = {N{10'd1023}};
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_to(e + 5);
        chk("sb_done_cnt", done_e.size(), 1);
        if (done_e.size() > 0) chk("sb_done_lat", done_e[0] - s, 48);
        chk("sb_mv0", row_mv[0 +: 16], 14);
        chk("sb_mv7", row_mv[7*16 +: 16], 219);

        c = '{default: 512};
        l = '{15, 4, 4, 4, 4, 4, 4, 4};
        clear_obs();
        go(c, l, s, e);
        wait_to(e + 3);
        chk("col_err_cnt", err_e.size(), 0);
        chk("col_done_cnt", done_e.size(), 1);
        if (done_e.size() > 0) chk("col_done_lat", done_e[0] - s, 59);
        chk("col_mv0", row_mv[0 +: 16], 150);

        c = '{default: 1023};
        l = '{16, 4, 4, 4, 4, 4, 4, 4};
        clear_obs();
        go(c, l, s, e);
        wait_to(e + 5);
        chk("late_err_cnt", err_e.size(), 1);
        if (err_e.size() > 0) chk("late_err_lat", err_e[0] - s, 17);
        chk("late_mv0_kept", row_mv[0 +: 16], 150);

        c = '{default: 1023};
        l = '{default: 4};
        go(c, l, s, e);
        wait_to(s + 12);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        flush();
        #1;
        chk("arst_valid", dif.dac_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_row_mv", (row_mv == '0), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        repeat (30) @(negedge clk);
        chk("arst_no_req", n_valid, 0);
        chk("arst_no_pulse", done_e.size() + err_e.size(), 0);

        c = '{default: 0};
        l = '{default: 4};
        clear_obs();
        go(c, l, s, e);
        wait_to(e + 3);
        chk("zero_done_cnt", done_e.size(), 1);
        if (done_e.size() > 0) chk("zero_done_lat", done_e[0] - s, SKIP ? 8 : 48);
        chk("zero_valid_cnt", n_valid, SKIP ? 0 : 8);

        c = '{0, 512, 0, 512, 0, 0, 0, 512};
        clear_obs();
        go(c, l, s, e);
        wait_to(e + 3);
        if (done_e.size() > 0) chk("mix_done_lat", done_e[0] - s, SKIP ? 23 : 48);
        chk("mix_valid_cnt", n_valid, SKIP ? 3 : 8);
        chk("mix_mv1", row_mv[16 +: 16], 150);

        c = '{default: 300};
        clear_obs();
        @(negedge clk);
        row_codes = pack(c);
        start = 1'b1;
        s = cyc + 1;
        e = plan(s, c, l);
        s2 = e + 1;
        e2 = plan(s2, c, l);
        wait_to(s2);
        start = 1'b0;
        wait_to(e2 + 5);
        chk("hold_done_cnt", done_e.size(), 2);
        if (done_e.size() > 1) chk("hold_done_gap", done_e[1] - done_e[0], 49);
        chk("hold_mv3", row_mv[3*16 +: 16], 87);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
